// File: rtl/zbuffer_writer.sv
// Depth-tested pixel writer: reads the stored depth, compares, then writes color and depth
// through one Avalon-style master. Also counts committed and rejected pixels.
module zbuffer_writer #(
  parameter bit DEPTH_TEST_EN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [25:0] addr_in,
  input  logic [23:0] color_in,
  input  logic [31:0] depth_in,
  input  logic        in_data_valid,
  input  logic        done_in,
  output logic        stall_out,
  output logic        done_out,
  output logic [25:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid,
  input  logic        stats_clear,
  output logic [31:0] pix_written,
  output logic [31:0] pix_rejected
);

  typedef enum logic [2:0] {IDLE, RD_Z, WAIT_Z, WR_C, WR_Z} state_t;

  state_t      state_reg, state_next;
  logic [25:0] addr_reg;
  logic [23:0] color_reg;
  logic [31:0] depth_reg;
  logic [25:0] depth_addr;
  logic        accept;
  logic        depth_pass;
  logic        written_inc;
  logic        rejected_inc;

  // Depth word sits 4 bytes above the color word; the 26-bit sum wraps naturally.
  assign depth_addr     = addr_reg + 26'd4;
  assign depth_pass     = $signed(depth_reg) < $signed(mem_readdata);
  assign accept         = (state_reg == IDLE) && in_data_valid && !stall_out;
  assign mem_byteenable = 4'hF;

  always_comb begin
    state_next    = state_reg;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_addr      = addr_reg;
    mem_writedata = depth_reg;
    written_inc   = 1'b0;
    rejected_inc  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = DEPTH_TEST_EN ? RD_Z : WR_C;
      end
      RD_Z: begin
        mem_read = 1'b1;
        mem_addr = depth_addr;
        if (!mem_waitrequest) state_next = WAIT_Z;
      end
      WAIT_Z: begin
        if (mem_readdatavalid) begin
          if (depth_pass) begin
            state_next = WR_C;
          end else begin
            state_next   = IDLE;
            rejected_inc = 1'b1;
          end
        end
      end
      WR_C: begin
        mem_write     = 1'b1;
        mem_writedata = {8'h00, color_reg};
        if (!mem_waitrequest) state_next = WR_Z;
      end
      WR_Z: begin
        mem_write = 1'b1;
        mem_addr  = depth_addr;
        if (!mem_waitrequest) begin
          state_next  = IDLE;
          written_inc = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      stall_out <= 1'b1;
      done_out  <= 1'b0;
    end else begin
      state_reg <= state_next;
      stall_out <= (state_next != IDLE);
      done_out  <= done_in && (state_reg == IDLE) && !in_data_valid;
    end
  end

  // Pixel capture needs no reset: it is only consumed after an accept.
  always_ff @(posedge clock) begin
    if (accept) begin
      addr_reg  <= addr_in;
      color_reg <= color_in;
      depth_reg <= depth_in;
    end
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clock) begin
    if (reset || stats_clear) begin
      pix_written  <= 32'd0;
      pix_rejected <= 32'd0;
    end else begin
      if (written_inc)  pix_written  <= pix_written + 32'd1;
      if (rejected_inc) pix_rejected <= pix_rejected + 32'd1;
    end
  end

endmodule

// File: tb/tb_zbuffer_writer.sv
// Randomized scoreboard bench for zbuffer_writer: a memory slave model with configurable
// waitrequest/read latency, a pixel-level reference model, and a bus monitor.
module tb_zbuffer_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic [25:0] addr_in;
  logic [23:0] color_in;
  logic [31:0] depth_in;
  logic        in_data_valid;
  logic        done_in;
  logic        stall_out;
  logic        done_out;
  logic [25:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic        mem_readdatavalid;
  logic        stats_clear;
  logic [31:0] pix_written;
  logic [31:0] pix_rejected;

  always #5 clock = ~clock;

  zbuffer_writer #(.DEPTH_TEST_EN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .addr_in(addr_in), .color_in(color_in), .depth_in(depth_in),
    .in_data_valid(in_data_valid), .done_in(done_in),
    .stall_out(stall_out), .done_out(done_out),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .stats_clear(stats_clear),
    .pix_written(pix_written), .pix_rejected(pix_rejected)
  );

  typedef struct { bit is_write; logic [25:0] addr; logic [31:0] data; } txn_t;
  typedef struct { int due; logic [31:0] data; } rd_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  txn_t        exp_q[$];
  rd_t         rd_q[$];
  logic [31:0] ref_mem   [logic [25:0]];
  logic [31:0] slave_mem [logic [25:0]];
  int          wait_mode = 0;   // 0 none, 1 three cycles per request, 2 random
  int          lat_min = 1;
  int          lat_max = 1;
  logic [31:0] exp_written = 0;
  logic [31:0] exp_rejected = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] default_word(input logic [25:0] a);
    return {6'h0, a} * 32'h9E3779B1;
  endfunction

  function automatic logic [31:0] ref_read(input logic [25:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : default_word(a);
  endfunction

  function automatic logic [31:0] slave_read(input logic [25:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : default_word(a);
  endfunction

  task automatic preload(input logic [25:0] a, input logic [31:0] v);
    ref_mem[a]   = v;
    slave_mem[a] = v;
  endtask

  // Memory slave and bus monitor: decides waitrequest, scoreboards each accepted request.
  initial begin : slave
    txn_t        e;
    rd_t         r;
    bit          held = 0;
    bit          wr_req;
    logic        sv_rd, sv_wr;
    logic [25:0] sv_addr;
    logic [31:0] sv_data;
    int          wait_cnt = 0;
    mem_waitrequest   = 1'b0;
    mem_readdatavalid = 1'b0;
    mem_readdata      = 32'h0;
    forever begin
      @(negedge clock);
      if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        r = rd_q.pop_front();
        mem_readdatavalid = 1'b1;
        mem_readdata      = r.data;
      end else begin
        mem_readdatavalid = 1'b0;
        mem_readdata      = $urandom;
      end
      if (reset) begin
        mem_waitrequest = 1'b0;
        held = 0;
        wait_cnt = 0;
      end else if (mem_read || mem_write) begin
        check("rw_exclusive", 32'(mem_read & mem_write), 32'h0);
        if (held) begin
          check("hold_read", 32'(mem_read), 32'(sv_rd));
          check("hold_write", 32'(mem_write), 32'(sv_wr));
          check("hold_addr", 32'(mem_addr), 32'(sv_addr));
          if (sv_wr) check("hold_wdata", mem_writedata, sv_data);
        end
        case (wait_mode)
          1:       wr_req = (wait_cnt < 3);
          2:       wr_req = ($urandom_range(0, 2) == 0);
          default: wr_req = 0;
        endcase
        mem_waitrequest = wr_req;
        if (wr_req) begin
          wait_cnt++;
          held = 1;
          sv_rd = mem_read; sv_wr = mem_write; sv_addr = mem_addr; sv_data = mem_writedata;
        end else begin
          wait_cnt = 0;
          held = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn: got write=%0b addr %h data %h expected none",
                     mem_write, mem_addr, mem_writedata);
          end else begin
            e = exp_q.pop_front();
            check("txn_kind", 32'(mem_write), 32'(e.is_write));
            check("txn_addr", 32'(mem_addr), 32'(e.addr));
            if (e.is_write) check("txn_wdata", mem_writedata, e.data);
            check("byteenable", 32'(mem_byteenable), 32'hF);
          end
          if (mem_write) begin
            slave_mem[mem_addr] = mem_writedata;
          end else begin
            r.due  = cyc + $urandom_range(lat_min, lat_max);
            r.data = slave_read(mem_addr);
            rd_q.push_back(r);
          end
        end
      end else begin
        mem_waitrequest = (wait_mode == 2) && ($urandom_range(0, 1) == 1);
        held = 0;
        wait_cnt = 0;
      end
    end
  end

  // Reference model: one pixel's bus traffic, counter effect and best-case latency.
  task automatic model_pixel(input logic [25:0] a, input logic [23:0] c, input logic [31:0] d,
                             output int lat_exp);
    txn_t        t;
    logic [25:0] za;
    logic [31:0] stored;
    bit          pass;
    int          w;
    za = a + 26'd4;
    stored = ref_read(za);
    pass = ($signed(d) < $signed(stored));
    t.is_write = 0; t.addr = za; t.data = 32'h0;
    exp_q.push_back(t);
    if (pass) begin
      t.is_write = 1; t.addr = a;  t.data = {8'h00, c};
      exp_q.push_back(t);
      t.is_write = 1; t.addr = za; t.data = d;
      exp_q.push_back(t);
      ref_mem[a]  = {8'h00, c};
      ref_mem[za] = d;
      exp_written = exp_written + 1;
    end else begin
      exp_rejected = exp_rejected + 1;
    end
    w = (wait_mode == 1) ? 3 : 0;
    lat_exp = pass ? (5 + 3 * w + lat_min - 1) : (3 + w + lat_min - 1);
  endtask

  task automatic accept_pixel(input logic [25:0] a, input logic [23:0] c, input logic [31:0] d);
    int n = 0;
    @(negedge clock);
    while (stall_out && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (stall_out) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got stall_out=1 expected 0");
    end
    addr_in = a; color_in = c; depth_in = d; in_data_valid = 1'b1;
    @(posedge clock);
    #1;
    in_data_valid = 1'b0;
    addr_in = 26'($urandom); color_in = 24'($urandom); depth_in = $urandom;
  endtask

  // Cycle index (acceptance cycle = 0) at which stall_out is first seen low.
  task automatic wait_idle(output int lat);
    lat = 1;
    forever begin
      @(negedge clock);
      if (!stall_out) break;
      if (lat > 300) begin
        checks++;
        errors++;
        $display("FAIL idle_timeout: got stall_out=1 expected 0");
        break;
      end
      @(posedge clock);
      lat++;
    end
  endtask

  task automatic run_pixel(input logic [25:0] a, input logic [23:0] c, input logic [31:0] d);
    int lat_exp, lat;
    model_pixel(a, c, d, lat_exp);
    accept_pixel(a, c, d);
    wait_idle(lat);
    if (wait_mode != 2 && lat_min == lat_max) check("latency", 32'(lat), 32'(lat_exp));
    check("pix_written", pix_written, exp_written);
    check("pix_rejected", pix_rejected, exp_rejected);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int          lat_exp;
    logic [25:0] a;
    logic [31:0] d;
    txn_t        t;
    reset = 1'b1; in_data_valid = 1'b0; done_in = 1'b0; stats_clear = 1'b0;
    addr_in = 26'h0; color_in = 24'h0; depth_in = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_stall", 32'(stall_out), 32'h1);
    check("rst_done", 32'(done_out), 32'h0);
    check("rst_read", 32'(mem_read), 32'h0);
    check("rst_write", 32'(mem_write), 32'h0);
    check("rst_written", pix_written, 32'h0);
    check("rst_rejected", pix_rejected, 32'h0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("stall_after_rst", 32'(stall_out), 32'h0);

    // Reset while waiting for read data; the late readdatavalid must be ignored.
    wait_mode = 0; lat_min = 6; lat_max = 6;
    t.is_write = 0; t.addr = 26'h204; t.data = 32'h0;
    exp_q.push_back(t);
    accept_pixel(26'h200, 24'h111111, 32'h80000000);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_stall", 32'(stall_out), 32'h1);
    check("midrst_read", 32'(mem_read), 32'h0);
    check("midrst_write", 32'(mem_write), 32'h0);
    @(posedge clock);
    #1 reset = 1'b0;
    check("midrst_stall_hold", 32'(stall_out), 32'h1);
    @(posedge clock);
    #1;
    check("midrst_stall_low", 32'(stall_out), 32'h0);
    repeat (10) @(posedge clock);
    #1;
    check("midrst_written", pix_written, 32'h0);
    check("midrst_rejected", pix_rejected, 32'h0);
    check("midrst_stall_end", 32'(stall_out), 32'h0);
    check("midrst_drain", 32'(exp_q.size()), 32'h0);

    // Best case pass, then greater and equal depths rejected.
    lat_min = 1; lat_max = 1;
    preload(26'h104, 32'h7FFFFFFF);
    run_pixel(26'h100, 24'h123456, 32'h00010000);
    run_pixel(26'h100, 24'hABCDEF, 32'h00020000);
    run_pixel(26'h100, 24'hABCDEF, 32'h00010000);

    // Three waitrequest cycles per request and read latency 4.
    wait_mode = 1; lat_min = 4; lat_max = 4;
    preload(26'h20C, 32'h40000000);
    run_pixel(26'h208, 24'h0F0F0F, 32'h00001234);
    run_pixel(26'h208, 24'h0F0F0F, 32'h00002000);

    // Signed compare and address wrap.
    wait_mode = 0; lat_min = 1; lat_max = 1;
    preload(26'h0000000, 32'h00000000);
    run_pixel(26'h3FFFFFC, 24'h00FF00, 32'hFFFF0000);

    // done_out held low while a pixel is in flight.
    preload(26'h404, 32'h7FFFFFFF);
    done_in = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("done_idle", 32'(done_out), 32'h1);
    model_pixel(26'h400, 24'h222222, 32'h00000100, lat_exp);
    accept_pixel(26'h400, 24'h222222, 32'h00000100);
    repeat (4) begin
      @(negedge clock);
      check("done_busy", 32'(done_out), 32'h0);
      @(posedge clock);
    end
    @(negedge clock);
    check("done_stall_low", 32'(stall_out), 32'h0);
    check("done_not_yet", 32'(done_out), 32'h0);
    @(posedge clock);
    #1;
    check("done_rise", 32'(done_out), 32'h1);
    done_in = 1'b0;
    @(posedge clock);
    #1;
    check("done_drop", 32'(done_out), 32'h0);
    check("done_written", pix_written, exp_written);

    // stats_clear coincident with the depth-write commit.
    preload(26'h304, 32'h7FFFFFFF);
    model_pixel(26'h300, 24'h333333, 32'h00000010, lat_exp);
    accept_pixel(26'h300, 24'h333333, 32'h00000010);
    repeat (3) @(posedge clock);
    #1 stats_clear = 1'b1;
    @(posedge clock);
    #1 stats_clear = 1'b0;
    exp_written = 0;
    exp_rejected = 0;
    check("clear_written", pix_written, 32'h0);
    check("clear_rejected", pix_rejected, 32'h0);
    check("clear_stall", 32'(stall_out), 32'h0);
    run_pixel(26'h500, 24'h444444, 32'h80000000);

    // Randomized traffic over a small address pool so depths collide.
    for (int i = 0; i < 60; i++) begin
      wait_mode = $urandom_range(0, 2);
      lat_min   = $urandom_range(1, 4);
      lat_max   = (wait_mode == 2) ? lat_min + $urandom_range(0, 3) : lat_min;
      a = 26'h1000 + {20'h0, 3'($urandom_range(0, 7)), 3'b000};
      if ($urandom_range(0, 7) == 0) begin
        d = ref_read(a + 26'd4);
      end else begin
        d = $urandom;
      end
      run_pixel(a, 24'($urandom), d);
    end

    repeat (10) @(posedge clock);
    #1;
    check("final_drain", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
